// File: rtl/enemy_fleet_ctrl.sv
// Enemy fleet controller: owns slot positions and alive mask, steps the fleet
// sideways once every FRAME_DIV frames (dropping and reversing at a screen
// edge), and picks which slot feeds the shared enemy sprite printer per pixel.
//
// state   | meaning
// S_IDLE  | waiting for the frame that triggers a fleet update
// S_CHECK | visiting slots 0..N-1, flagging any live slot that would cross an edge
// S_MOVE  | visiting slots 0..N-1, stepping sideways or dropping a row
module enemy_fleet_ctrl #(
  parameter int N_ENEMIES = 4,
  parameter int SPRITE_W  = 64,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int STEP_X    = 2,
  parameter int STEP_Y    = 16,
  parameter int FRAME_DIV = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_frame_start,
  input  logic                 i_kill_valid,
  input  logic [2:0]           i_kill_idx,
  input  logic [9:0]           i_pixelx,
  input  logic [9:0]           i_pixely,
  output logic [9:0]           o_posx,
  output logic [9:0]           o_posy,
  output logic                 o_slot_active,
  output logic [N_ENEMIES-1:0] o_alive,
  output logic                 o_busy,
  output logic                 o_fleet_cleared,
  output logic                 o_reached_bottom
);

  localparam logic [10:0] C_SPRITE_W = 11'(SPRITE_W);
  localparam logic [10:0] C_SCREEN_W = 11'(SCREEN_W);
  localparam logic [10:0] C_STEP_X   = 11'(STEP_X);
  localparam logic [10:0] C_STEP_Y   = 11'(STEP_Y);
  localparam logic [10:0] C_Y_MAX    = 11'(SCREEN_H - SPRITE_W);
  localparam logic [2:0]  C_LAST_IDX = 3'(N_ENEMIES - 1);
  localparam logic [7:0]  C_CNT_MAX  = 8'(FRAME_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_MOVE  = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [2:0]           r_idx, w_idx_nxt;
  logic [7:0]           r_frame_cnt;
  logic [10:0]          r_x [N_ENEMIES];
  logic [10:0]          r_y [N_ENEMIES];
  logic [N_ENEMIES-1:0] r_alive;
  logic                 r_dir_right;
  logic                 r_edge_hit;
  logic                 r_cleared;
  logic                 r_bottom;
  logic                 r_active;
  logic [9:0]           r_posx, r_posy;

  logic                 w_start, w_last;
  logic [10:0]          w_cur_x, w_cur_y;
  logic                 w_cur_alive, w_cur_edge;
  logic [10:0]          w_y_sum, w_y_down;
  logic [10:0]          w_px, w_py;
  logic                 w_hit_any;
  logic [10:0]          w_sel_x, w_sel_y;

  // State and slot index register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state: each active phase walks every slot exactly once
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_start     = 1'b0;
    w_last      = (r_idx == C_LAST_IDX);
    case (r_state)
      S_IDLE: begin
        if (i_frame_start && (r_frame_cnt == C_CNT_MAX)) begin
          w_start     = 1'b1;
          w_state_nxt = S_CHECK;
          w_idx_nxt   = '0;
        end
      end
      S_CHECK: begin
        if (w_last) begin
          w_state_nxt = S_MOVE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 3'd1;
        end
      end
      S_MOVE: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 3'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Frame divider; frames seen while an update runs are not counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if ((r_state == S_IDLE) && i_frame_start) begin
      r_frame_cnt <= (r_frame_cnt == C_CNT_MAX) ? 8'd0 : r_frame_cnt + 8'd1;
    end
  end

  // Mux out the slot currently visited by CHECK/MOVE
  always_comb begin
    w_cur_x     = '0;
    w_cur_y     = '0;
    w_cur_alive = 1'b0;
    for (int i = 0; i < N_ENEMIES; i++) begin
      if (r_idx == 3'(i)) begin
        w_cur_x     = r_x[i];
        w_cur_y     = r_y[i];
        w_cur_alive = r_alive[i];
      end
    end
  end

  assign w_cur_edge = r_dir_right ? ((w_cur_x + C_STEP_X + C_SPRITE_W) > C_SCREEN_W)
                                  : (w_cur_x < C_STEP_X);
  assign w_y_sum    = w_cur_y + C_STEP_Y;
  assign w_y_down   = (w_y_sum > C_Y_MAX) ? C_Y_MAX : w_y_sum;

  // Fleet datapath: edge detection, moves, direction, kills and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENEMIES; i++) begin
        r_x[i] <= 11'(i * (SPRITE_W + 16));
        r_y[i] <= '0;
      end
      r_alive     <= '1;
      r_dir_right <= 1'b1;
      r_edge_hit  <= 1'b0;
      r_cleared   <= 1'b0;
      r_bottom    <= 1'b0;
    end else begin
      if (w_start) begin
        r_edge_hit <= 1'b0;
      end else if ((r_state == S_CHECK) && w_cur_alive && w_cur_edge) begin
        r_edge_hit <= 1'b1;
      end
      for (int i = 0; i < N_ENEMIES; i++) begin
        if ((r_state == S_MOVE) && (r_idx == 3'(i)) && r_alive[i]) begin
          if (r_edge_hit) begin
            r_y[i] <= w_y_down;
          end else if (r_dir_right) begin
            r_x[i] <= r_x[i] + C_STEP_X;
          end else begin
            r_x[i] <= r_x[i] - C_STEP_X;
          end
        end
      end
      if ((r_state == S_MOVE) && w_last && r_edge_hit) begin
        r_dir_right <= ~r_dir_right;
      end
      if ((r_state == S_MOVE) && w_cur_alive && r_edge_hit && (w_y_down == C_Y_MAX)) begin
        r_bottom <= 1'b1;
      end
      // a kill landing on the slot being moved still lets that move complete
      for (int i = 0; i < N_ENEMIES; i++) begin
        if (i_kill_valid && (i_kill_idx == 3'(i))) begin
          r_alive[i] <= 1'b0;
        end
      end
      r_cleared <= (r_alive == '0);
    end
  end

  assign w_px = {1'b0, i_pixelx};
  assign w_py = {1'b0, i_pixely};

  // Pixel hit search, descending so the lowest hitting slot wins
  always_comb begin
    w_hit_any = 1'b0;
    w_sel_x   = '0;
    w_sel_y   = '0;
    for (int i = N_ENEMIES - 1; i >= 0; i--) begin
      if (r_alive[i] &&
          (w_px >= r_x[i]) && (w_px < (r_x[i] + C_SPRITE_W)) &&
          (w_py >= r_y[i]) && (w_py < (r_y[i] + C_SPRITE_W))) begin
        w_hit_any = 1'b1;
        w_sel_x   = r_x[i];
        w_sel_y   = r_y[i];
      end
    end
  end

  // Register the selection to line up with the sprite ROM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_posx   <= '0;
      r_posy   <= '0;
    end else begin
      r_active <= w_hit_any;
      if (w_hit_any) begin
        r_posx <= w_sel_x[9:0];
        r_posy <= w_sel_y[9:0];
      end
    end
  end

  assign o_posx           = r_posx;
  assign o_posy           = r_posy;
  assign o_slot_active    = r_active;
  assign o_alive          = r_alive;
  assign o_busy           = (r_state != S_IDLE);
  assign o_fleet_cleared  = r_cleared;
  assign o_reached_bottom = r_bottom;

endmodule
